alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (1 = reset; port name kept per codebase).
REQ-003 SHALL have port i_valid, input, 1 bit: upstream instruction valid.
REQ-004 SHALL have port i_next, output, 1 bit: ALU ready to accept from upstream.
REQ-005 SHALL have ports i_rs1en and i_rs2en, input, 1 bit each: rs1 used / rs2 used (when 0, immediate replaces rs2).
REQ-006 SHALL have ports i_rs1 and i_rs2, input, 32 bits each: register operands.
REQ-007 SHALL have port i_imm, input, 32 bits: sign-extended immediate; for OP, i_imm[10] carries instr[30].
REQ-008 SHALL have port i_opcode, input, 5 bits: instr[6:2].
REQ-009 SHALL have port i_memen, input, 1 bit: load/store instruction.
REQ-010 SHALL have port i_regen, input, 1 bit: writes rd.
REQ-011 SHALL have port i_memstrb, input, 3 bits: funct3 (mem width, branch condition or ALU op).
REQ-012 SHALL have port i_pc, input, 33 bits: [31:0] instruction address; [32] predicted-taken flag.
REQ-013 SHALL have port i_rd, input, 5 bits: destination register.
REQ-014 SHALL have port o_next, input, 1 bit: downstream ready.
REQ-015 SHALL have outputs o_valid (1), o_result (32), o_rd (5), o_regen (1), o_memen (1), o_memstrb (3), o_memwe (1) and o_memdata (32): registered result stage.
REQ-016 SHALL have outputs c_flush (1) and c_pc (32): pipeline flush request and redirect PC.

Function
REQ-017 SHALL compute a = i_rs1en ? i_rs1 : 0 and b = i_rs2en ? i_rs2 : i_imm.
REQ-018 SHALL, for opcode 00100 (OP-IMM) and 01100 (OP), implement funct3 as follows:
- 000: ADD, or SUB when OP and i_imm[10]=1.
- 001: SLL.
- 010: SLT.
- 011: SLTU.
- 100: XOR.
- 101: SRL, or SRA when i_imm[10]=1.
- 110: OR.
- 111: AND.
- Shift amount is b[4:0].
REQ-019 SHALL give LUI (01101) result i_imm and AUIPC (00101) result pc+i_imm.
REQ-020 SHALL give JAL (11011) and JALR (11001) result pc+4; targets: JAL pc+i_imm, JALR (i_rs1+i_imm) with bit0 cleared.
REQ-021 SHALL, for LOAD (00000) and STORE (01000), set o_result = i_rs1+i_imm, o_memdata = i_rs2, o_memwe = 1 for STORE only.
REQ-022 SHALL, for BRANCH (11000), evaluate funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; target pc+i_imm; o_regen forced 0.
REQ-023 SHALL treat any other opcode as a NOP: o_regen=0, o_memen=0.
REQ-024 SHALL assert i_next = ~o_valid | o_next; an instruction is accepted when i_valid & i_next.
REQ-025 SHALL register results with 1-cycle latency; o_valid holds until o_next=1.
REQ-026 SHALL, on acceptance of a jump or branch whose actual taken differs from i_pc[32], pulse c_flush high for exactly 1 cycle on the next edge; c_pc = taken ? target : pc+4.
REQ-027 SHALL, while c_flush=1, discard any instruction presented (no acceptance, o_valid not set by it).
REQ-028 SHALL keep o_valid for the flushing instruction itself (jump link writes still retire).
REQ-029 SHALL give reset priority over flush and acceptance when asserted simultaneously.

Reset
REQ-030 SHALL, on rst_n=1 at a clock edge, clear o_valid, c_flush, o_regen, o_memen and o_memwe to 0 and clear c_pc, o_result, o_memdata, o_rd and o_memstrb to 0.
REQ-031 SHALL drop any in-flight result when reset is asserted mid-operation; i_next=1 in the first cycle after reset.

Configuration
REQ-032 SHALL, with macro ALU_PREDICT_BIT_EN defined, use i_pc[32] as the prediction per REQ-026.
REQ-033 SHALL, without ALU_PREDICT_BIT_EN, ignore i_pc[32], treat every instruction as predicted not-taken and flush on every taken branch/jump.

Verification
REQ-034 SHALL verify: OP ADD, rs1=5, rs2=7 -> o_result=12 one cycle later, o_valid=1.
REQ-035 SHALL verify: OP with i_imm[10]=1, funct3=101, rs1=0x80000000, rs2=4 -> o_result=0xF8000000.
REQ-036 SHALL verify: BEQ pc=0x100, imm=0x20, rs1=rs2=3, i_pc[32]=0 -> c_flush 1-cycle pulse, c_pc=0x120, next input discarded.
REQ-037 SHALL verify: JALR pc=0x40, rs1=0x1001, imm=2 -> o_result=0x44, c_pc=0x1002.
REQ-038 SHALL verify: o_next=0 with o_valid=1 -> i_next=0, outputs held, no acceptance.
REQ-039 SHALL verify: rst_n=1 mid-stream with i_valid=1 -> next cycle o_valid=0, c_flush=0, i_next=1.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - single-stage RV32I ALU/branch unit with registered result stage and flush/redirect
// Optional feature macro: ALU_PREDICT_BIT_EN (honour i_pc[32] as the predicted-taken flag)
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        i_next,
  input  logic        i_rs1en,
  input  logic        i_rs2en,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_opcode,
  input  logic        i_memen,
  input  logic        i_regen,
  input  logic [2:0]  i_memstrb,
  input  logic [32:0] i_pc,
  input  logic [4:0]  i_rd,
  input  logic        o_next,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_regen,
  output logic        o_memen,
  output logic [2:0]  o_memstrb,
  output logic        o_memwe,
  output logic [31:0] o_memdata,
  output logic        c_flush,
  output logic [31:0] c_pc
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  logic [31:0] a, b, pc, pc_plus4, add_sub, sra_res, alu_res;
  logic [4:0]  shamt;
  logic        br_eq, br_lt, br_ltu, pred, accept, mispredict;

  logic [31:0] result_d, memdata_d, target_d;
  logic        regen_d, memen_d, memwe_d, is_cf_d, taken_d;

  logic        valid_q, regen_q, memen_q, memwe_q, flush_q;
  logic [31:0] result_q, memdata_q, cpc_q;
  logic [4:0]  rd_q;
  logic [2:0]  memstrb_q;

  assign a        = i_rs1en ? i_rs1 : 32'd0;
  assign b        = i_rs2en ? i_rs2 : i_imm;
  assign pc       = i_pc[31:0];
  assign pc_plus4 = pc + 32'd4;
  assign shamt    = b[4:0];
  assign add_sub  = (i_opcode == OPC_OP && i_imm[10]) ? a - b : a + b;
  assign sra_res  = $signed(a) >>> shamt;
  assign br_eq    = (a == b);
  assign br_lt    = ($signed(a) < $signed(b));
  assign br_ltu   = (a < b);

`ifdef ALU_PREDICT_BIT_EN
  assign pred = i_pc[32];
`else
  logic unused_pred_bit;
  assign unused_pred_bit = i_pc[32];
  assign pred = 1'b0;
`endif

  always_comb begin
    alu_res = 32'd0;
    case (i_memstrb)
      3'b000:  alu_res = add_sub;
      3'b001:  alu_res = a << shamt;
      3'b010:  alu_res = {31'd0, br_lt};
      3'b011:  alu_res = {31'd0, br_ltu};
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = i_imm[10] ? sra_res : (a >> shamt);
      3'b110:  alu_res = a | b;
      default: alu_res = a & b;
    endcase
  end

  always_comb begin
    result_d  = 32'd0;
    memdata_d = 32'd0;
    target_d  = 32'd0;
    regen_d   = i_regen;
    memen_d   = i_memen;
    memwe_d   = 1'b0;
    is_cf_d   = 1'b0;
    taken_d   = 1'b0;
    case (i_opcode)
      OPC_OP, OPC_OPIMM: result_d = alu_res;
      OPC_LUI:           result_d = i_imm;
      OPC_AUIPC:         result_d = pc + i_imm;
      OPC_JAL: begin
        result_d = pc_plus4;
        is_cf_d  = 1'b1;
        taken_d  = 1'b1;
        target_d = pc + i_imm;
      end
      OPC_JALR: begin
        result_d = pc_plus4;
        is_cf_d  = 1'b1;
        taken_d  = 1'b1;
        target_d = (i_rs1 + i_imm) & ~32'd1;
      end
      OPC_LOAD, OPC_STORE: begin
        result_d  = i_rs1 + i_imm;
        memdata_d = i_rs2;
        memwe_d   = (i_opcode == OPC_STORE);
      end
      OPC_BRANCH: begin
        regen_d  = 1'b0;
        is_cf_d  = 1'b1;
        target_d = pc + i_imm;
        case (i_memstrb)
          3'b000:  taken_d = br_eq;
          3'b001:  taken_d = ~br_eq;
          3'b100:  taken_d = br_lt;
          3'b101:  taken_d = ~br_lt;
          3'b110:  taken_d = br_ltu;
          3'b111:  taken_d = ~br_ltu;
          default: taken_d = 1'b0;
        endcase
      end
      default: begin
        regen_d = 1'b0;
        memen_d = 1'b0;
      end
    endcase
  end

  // Instructions arriving in the cycle after a redirect are on the wrong path.
  assign i_next     = ~valid_q | o_next;
  assign accept     = i_valid & i_next & ~flush_q;
  assign mispredict = is_cf_d & (taken_d != pred);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
      regen_q   <= 1'b0;
      memen_q   <= 1'b0;
      memwe_q   <= 1'b0;
      cpc_q     <= 32'd0;
      result_q  <= 32'd0;
      memdata_q <= 32'd0;
      rd_q      <= 5'd0;
      memstrb_q <= 3'd0;
    end else begin
      flush_q <= accept & mispredict;
      if (accept & mispredict)
        cpc_q <= taken_d ? target_d : pc_plus4;
      if (accept) begin
        valid_q   <= 1'b1;
        result_q  <= result_d;
        memdata_q <= memdata_d;
        regen_q   <= regen_d;
        memen_q   <= memen_d;
        memwe_q   <= memwe_d;
        rd_q      <= i_rd;
        memstrb_q <= i_memstrb;
      end else if (o_next) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_result  = result_q;
  assign o_rd      = rd_q;
  assign o_regen   = regen_q;
  assign o_memen   = memen_q;
  assign o_memstrb = memstrb_q;
  assign o_memwe   = memwe_q;
  assign o_memdata = memdata_q;
  assign c_flush   = flush_q;
  assign c_pc      = cpc_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: directed cases plus randomized traffic against a behavioural model
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_next;
  logic        i_rs1en;
  logic        i_rs2en;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] i_imm;
  logic [4:0]  i_opcode;
  logic        i_memen;
  logic        i_regen;
  logic [2:0]  i_memstrb;
  logic [32:0] i_pc;
  logic [4:0]  i_rd;
  logic        o_next;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_regen;
  logic        o_memen;
  logic [2:0]  o_memstrb;
  logic        o_memwe;
  logic [31:0] o_memdata;
  logic        c_flush;
  logic [31:0] c_pc;

  alu dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_next(i_next),
    .i_rs1en(i_rs1en), .i_rs2en(i_rs2en), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_imm(i_imm), .i_opcode(i_opcode), .i_memen(i_memen), .i_regen(i_regen),
    .i_memstrb(i_memstrb), .i_pc(i_pc), .i_rd(i_rd), .o_next(o_next),
    .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd), .o_regen(o_regen),
    .o_memen(o_memen), .o_memstrb(o_memstrb), .o_memwe(o_memwe),
    .o_memdata(o_memdata), .c_flush(c_flush), .c_pc(c_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] result;
    logic        rdef;
    logic [31:0] memdata;
    logic        mdef;
    logic        regen;
    logic        memen;
    logic        memwe;
    logic        cf;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  // Reference semantics of one instruction, from the ISA rules.
  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, b, pc;
    logic signed [31:0] sa, sb;
    int unsigned sh;
    e  = '0;
    a  = i_rs1en ? i_rs1 : 32'd0;
    b  = i_rs2en ? i_rs2 : i_imm;
    sa = a;
    sb = b;
    sh = b % 32;
    pc = i_pc[31:0];
    e.regen = i_regen;
    e.memen = i_memen;
    if (i_opcode == 5'b00100 || i_opcode == 5'b01100) begin
      e.rdef = 1;
      case (i_memstrb)
        3'd0: e.result = (i_opcode == 5'b01100 && i_imm[10]) ? a - b : a + b;
        3'd1: e.result = a << sh;
        3'd2: e.result = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: e.result = (a < b) ? 32'd1 : 32'd0;
        3'd4: e.result = a ^ b;
        3'd5: begin
          if (i_imm[10]) begin
            sa = sa >>> sh;
            e.result = sa;
          end else begin
            e.result = a >> sh;
          end
        end
        3'd6: e.result = a | b;
        default: e.result = a & b;
      endcase
    end else if (i_opcode == 5'b01101) begin
      e.rdef = 1; e.result = i_imm;
    end else if (i_opcode == 5'b00101) begin
      e.rdef = 1; e.result = pc + i_imm;
    end else if (i_opcode == 5'b11011 || i_opcode == 5'b11001) begin
      e.rdef = 1; e.result = pc + 4;
      e.cf = 1; e.taken = 1;
      e.target = (i_opcode == 5'b11011) ? pc + i_imm : ((i_rs1 + i_imm) & 32'hFFFF_FFFE);
    end else if (i_opcode == 5'b00000 || i_opcode == 5'b01000) begin
      e.rdef = 1; e.result = i_rs1 + i_imm;
      e.mdef = 1; e.memdata = i_rs2;
      e.memwe = (i_opcode == 5'b01000);
    end else if (i_opcode == 5'b11000) begin
      e.regen = 0; e.cf = 1; e.target = pc + i_imm;
      case (i_memstrb)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = (sa < sb);
        3'd5: e.taken = (sa >= sb);
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: e.taken = 0;
      endcase
    end else begin
      e.regen = 0; e.memen = 0;
    end
    return e;
  endfunction

  function automatic logic predicted();
`ifdef ALU_PREDICT_BIT_EN
    return i_pc[32];
`else
    return 1'b0;
`endif
  endfunction

  logic        m_valid, m_flush;
  logic [31:0] m_cpc;
  logic [4:0]  m_rd;
  logic [2:0]  m_strb;
  exp_t        m_e;

  always @(posedge clk) begin
    exp_t e;
    logic acc;
    e   = model();
    acc = i_valid && (!m_valid || o_next) && !m_flush;
    if (rst_n) begin
      m_valid <= 0; m_flush <= 0; m_cpc <= 0; m_rd <= 0; m_strb <= 0; m_e <= '0;
    end else begin
      m_flush <= acc && e.cf && (e.taken != predicted());
      if (acc && e.cf && (e.taken != predicted()))
        m_cpc <= e.taken ? e.target : i_pc[31:0] + 32'd4;
      if (acc) begin
        m_valid <= 1; m_e <= e; m_rd <= i_rd; m_strb <= i_memstrb;
      end else if (o_next) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("o_valid", o_valid, m_valid);
      chk("c_flush", c_flush, m_flush);
      chk("i_next", i_next, !m_valid || o_next);
      if (m_valid) begin
        chk("o_rd", o_rd, m_rd);
        chk("o_memstrb", o_memstrb, m_strb);
        chk("o_regen", o_regen, m_e.regen);
        chk("o_memen", o_memen, m_e.memen);
        chk("o_memwe", o_memwe, m_e.memwe);
        if (m_e.rdef) chk("o_result", o_result, m_e.result);
        if (m_e.mdef) chk("o_memdata", o_memdata, m_e.memdata);
      end
      if (m_flush) chk("c_pc", c_pc, m_cpc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [32:0] pc);
    i_valid = 1; i_rs1en = 1; i_rs2en = 1; i_regen = 1; i_memen = 0;
    i_opcode = op; i_memstrb = f3; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc;
    i_rd = 5'd7;
  endtask

  initial begin
    logic [4:0] ops [10];
    logic [31:0] r;
    ops = '{5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011,
            5'b11001, 5'b00000, 5'b01000, 5'b11000, 5'b11000};
    o_next = 1;
    rst_n  = 1;
    drive(5'b11011, 3'd0, 32'd1, 32'd2, 32'h40, 33'h80);
    step();
    check_en = 1;
    step();
    @(negedge clk);
    chk("rst o_valid", o_valid, 0);
    chk("rst c_flush", c_flush, 0);
    chk("rst i_next", i_next, 1);
    chk("rst o_result", o_result, 0);
    chk("rst c_pc", c_pc, 0);
    chk("rst o_memdata", o_memdata, 0);
    chk("rst o_rd", o_rd, 0);
    chk("rst o_memstrb", o_memstrb, 0);
    chk("rst o_regen", o_regen, 0);
    chk("rst o_memen", o_memen, 0);
    chk("rst o_memwe", o_memwe, 0);

    step();
    rst_n = 0;
    drive(5'b01100, 3'd0, 32'd5, 32'd7, 32'd0, 33'h0);
    step();
    i_valid = 0;
    @(negedge clk);
    chk("add o_valid", o_valid, 1);
    chk("add o_result", o_result, 32'd12);

    step();
    drive(5'b01100, 3'd5, 32'h8000_0000, 32'd4, 32'h400, 33'h0);
    step();
    i_valid = 0;
    @(negedge clk);
    chk("sra o_result", o_result, 32'hF800_0000);

    step();
    drive(5'b11000, 3'd0, 32'd3, 32'd3, 32'h20, 33'h100);
    step();
    drive(5'b01100, 3'd0, 32'd1, 32'd1, 32'd0, 33'h104);
    @(negedge clk);
    chk("beq c_flush", c_flush, 1);
    chk("beq c_pc", c_pc, 32'h120);
    chk("beq o_regen", o_regen, 0);
    step();
    i_valid = 0;
    @(negedge clk);
    chk("beq pulse end", c_flush, 0);
    chk("beq discard", o_valid, 0);

    step();
    drive(5'b11001, 3'd0, 32'h1001, 32'd0, 32'd2, 33'h40);
    i_rs2en = 0;
    step();
    i_valid = 0;
    @(negedge clk);
    chk("jalr o_result", o_result, 32'h44);
    chk("jalr c_pc", c_pc, 32'h1002);
    chk("jalr c_flush", c_flush, 1);

    step();
    drive(5'b01100, 3'd0, 32'd10, 32'd20, 32'd0, 33'h0);
    step();
    drive(5'b01100, 3'd4, 32'hF0, 32'h0F, 32'd0, 33'h4);
    o_next = 0;
    @(negedge clk);
    chk("stall i_next", i_next, 0);
    chk("stall o_result", o_result, 32'd30);
    step();
    @(negedge clk);
    chk("stall held valid", o_valid, 1);
    chk("stall held result", o_result, 32'd30);
    o_next = 1;
    step();
    i_valid = 0;
    @(negedge clk);
    chk("release o_result", o_result, 32'hFF);

    step();
    drive(5'b01100, 3'd0, 32'd1, 32'd2, 32'd0, 33'h0);
    step();
    drive(5'b11011, 3'd0, 32'd0, 32'd0, 32'h80, 33'h200);
    rst_n = 1;
    step();
    rst_n = 0;
    @(negedge clk);
    chk("midrst o_valid", o_valid, 0);
    chk("midrst c_flush", c_flush, 0);
    chk("midrst i_next", i_next, 1);

    for (int n = 0; n < 4000; n++) begin
      step();
      rst_n   = ($urandom_range(0, 199) == 0);
      i_valid = ($urandom_range(0, 9) < 7);
      o_next  = ($urandom_range(0, 3) != 0);
      i_opcode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 9)];
      i_memstrb = 3'($urandom);
      i_rs1en = ($urandom_range(0, 4) != 0);
      i_rs2en = ($urandom_range(0, 4) != 0);
      i_regen = 1'($urandom);
      i_memen = 1'($urandom);
      i_rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      case ($urandom_range(0, 3))
        0:       i_rs2 = i_rs1;
        1:       i_rs2 = 32'($urandom_range(0, 8));
        default: i_rs2 = $urandom;
      endcase
      r = $urandom;
      i_imm = ($urandom_range(0, 1) == 0) ? r : {{20{r[11]}}, r[11:0]};
      i_pc = {1'($urandom), $urandom};
      i_rd = 5'($urandom);
    end

    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
